// File: rtl/mac_dot_sequencer_if.sv
// Host and MAC-side signal bundle for mac_dot_sequencer.
// slave is the sequencer's view; master is the host plus the top_mac side.
interface mac_dot_sequencer_if #(
  parameter int N_MAX = 16,
  parameter int DW    = 8,
  parameter int ACCW  = 22
);
  localparam int AW = $clog2(N_MAX);

  logic            load_en;
  logic [AW-1:0]   load_addr;
  logic [DW-1:0]   load_a;
  logic [DW-1:0]   load_b;
  logic [AW:0]     len;
  logic            start;
  logic            busy;
  logic            err;
  logic            done;
  logic [ACCW-1:0] result;
  logic            mac_clr;
  logic [DW-1:0]   mac_a;
  logic [DW-1:0]   mac_b;
  logic [ACCW-1:0] mac_y;

  modport slave (
    input  load_en, load_addr, load_a, load_b, len, start, mac_y,
    output busy, err, done, result, mac_clr, mac_a, mac_b
  );

  modport master (
    output load_en, load_addr, load_a, load_b, len, start, mac_y,
    input  busy, err, done, result, mac_clr, mac_a, mac_b
  );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Streams two stored operand vectors into top_mac and captures the accumulated dot product.
// Outputs are registered from the current state, so they trail the state register by one cycle.
module mac_dot_sequencer #(
  parameter int N_MAX   = 16,
  parameter int DW      = 8,
  parameter int ACCW    = 22,
  parameter int MAC_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  mac_dot_sequencer_if.slave bus
);
  localparam int AW = $clog2(N_MAX);
  localparam logic [AW:0] LEN_MAX    = (AW+1)'(N_MAX);
  localparam logic [AW:0] DRAIN_LAST = (AW+1)'(MAC_LAT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_e;

  state_e          state_q, state_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [AW:0]     len_q, len_d;
  logic [DW-1:0]   mem_a_q [N_MAX];
  logic [DW-1:0]   mem_b_q [N_MAX];

  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic [ACCW-1:0] result_q, result_d;
  logic            mac_clr_q, mac_clr_d;
  logic [DW-1:0]   mac_a_q, mac_a_d;
  logic [DW-1:0]   mac_b_q, mac_b_d;

  logic len_ok, idle_free, accept, wr_en;

  // The done cycle is already IDLE in state_q but still busy, so starts wait one more cycle.
  assign idle_free = (state_q == IDLE) && !busy_q;
  assign len_ok    = (bus.len != '0) && (bus.len <= LEN_MAX);
  assign accept    = bus.start && idle_free && len_ok;
  assign wr_en     = bus.load_en && (state_q == IDLE) && ({1'b0, bus.load_addr} < LEN_MAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_MAX; i++) begin
        mem_a_q[i] <= '0;
        mem_b_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_a_q[bus.load_addr] <= bus.load_a;
      mem_b_q[bus.load_addr] <= bus.load_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      mac_clr_q <= 1'b0;
      mac_a_q   <= '0;
      mac_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      done_q    <= done_d;
      result_q  <= result_d;
      mac_clr_q <= mac_clr_d;
      mac_a_q   <= mac_a_d;
      mac_b_q   <= mac_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CLEAR;
          cnt_d   = '0;
          len_d   = bus.len;
        end
      end
      CLEAR: begin
        state_d = STREAM;
        cnt_d   = '0;
      end
      STREAM: begin
        if (cnt_q == len_q - 1'b1) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d    = accept || (busy_q && !done_q);
    err_d     = bus.start && idle_free && !len_ok;
    done_d    = (state_q == DONE);
    result_d  = (state_q == DONE) ? bus.mac_y : result_q;
    mac_clr_d = (state_q == CLEAR);
    mac_a_d   = '0;
    mac_b_d   = '0;
    if (state_q == STREAM) begin
      mac_a_d = mem_a_q[cnt_q[AW-1:0]];
      mac_b_d = mem_b_q[cnt_q[AW-1:0]];
    end
  end

  assign bus.busy    = busy_q;
  assign bus.err     = err_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.mac_clr = mac_clr_q;
  assign bus.mac_a   = mac_a_q;
  assign bus.mac_b   = mac_b_q;
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer with a one-cycle accumulating MAC model closing the loop.
module tb_mac_dot_sequencer;
  localparam int N_MAX = 16;
  localparam int DW    = 8;
  localparam int ACCW  = 22;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mac_dot_sequencer_if #(.N_MAX(N_MAX), .DW(DW), .ACCW(ACCW)) sif ();

  mac_dot_sequencer #(.N_MAX(N_MAX), .DW(DW), .ACCW(ACCW), .MAC_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always @(posedge clk)
    sif.mac_y <= sif.mac_clr ? '0 : sif.mac_y + ACCW'(sif.mac_a) * ACCW'(sif.mac_b);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [ACCW-1:0] val; } res_t;
  typedef struct { int cyc; logic [DW-1:0] a; logic [DW-1:0] b; } pair_t;
  res_t  res_q[$];
  pair_t pair_q[$];
  int    err_q[$];
  int    busy_chk_cyc = -1;
  int    n_cmp = 0;
  int    n_err = 0;
  logic [DW-1:0] sa [N_MAX];
  logic [DW-1:0] sb [N_MAX];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  always @(negedge clk) begin
    if (pair_q.size() > 0 && pair_q[0].cyc == cyc) begin
      chk("pair_a", 32'(sif.mac_a), 32'(pair_q[0].a));
      chk("pair_b", 32'(sif.mac_b), 32'(pair_q[0].b));
      void'(pair_q.pop_front());
    end
    if (sif.done) begin
      if (res_q.size() == 0) flag("unexpected_done");
      else begin
        chk("done_cycle", cyc, res_q[0].cyc);
        chk("result", 32'(sif.result), 32'(res_q[0].val));
        chk("busy_at_done", 32'(sif.busy), 1);
        void'(res_q.pop_front());
        busy_chk_cyc = cyc + 1;
      end
    end else if (res_q.size() > 0 && cyc > res_q[0].cyc) begin
      flag("done_missing");
      void'(res_q.pop_front());
    end
    if (busy_chk_cyc == cyc) begin
      chk("busy_after_done", 32'(sif.busy), 0);
      busy_chk_cyc = -1;
    end
    if (sif.err) begin
      if (err_q.size() == 0) flag("unexpected_err");
      else begin
        chk("err_cycle", cyc, err_q[0]);
        void'(err_q.pop_front());
      end
    end else if (err_q.size() > 0 && cyc > err_q[0]) begin
      flag("err_missing");
      void'(err_q.pop_front());
    end
  end

  task automatic load(input int addr, input int a, input int b);
    sif.load_en   = 1'b1;
    sif.load_addr = 4'(addr);
    sif.load_a    = 8'(a);
    sif.load_b    = 8'(b);
    sa[addr]      = 8'(a);
    sb[addr]      = 8'(b);
    @(negedge clk);
    sif.load_en   = 1'b0;
  endtask

  // Called at a negedge; may share the cycle with a load already driven by the caller.
  task automatic issue_start(input int n, input logic [ACCW-1:0] expv);
    pair_t p;
    res_t  r;
    sif.len   = 5'(n);
    sif.start = 1'b1;
    if (n >= 1 && n <= N_MAX) begin
      for (int i = 0; i < n; i++) begin
        p.cyc = cyc + 3 + i;
        p.a   = sa[i];
        p.b   = sb[i];
        pair_q.push_back(p);
      end
      r.cyc = cyc + n + 4;
      r.val = expv;
      res_q.push_back(r);
    end else begin
      err_q.push_back(cyc + 1);
    end
    @(negedge clk);
    sif.start   = 1'b0;
    sif.load_en = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!sif.done && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!sif.done) flag("timeout_done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    sif.load_en = 1'b0; sif.load_addr = '0; sif.load_a = '0; sif.load_b = '0;
    sif.len = '0; sif.start = 1'b0;
    for (int i = 0; i < N_MAX; i++) begin sa[i] = '0; sb[i] = '0; end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("rst_busy", 32'(sif.busy), 0);
    chk("rst_err", 32'(sif.err), 0);
    chk("rst_done", 32'(sif.done), 0);
    chk("rst_mac_clr", 32'(sif.mac_clr), 0);
    chk("rst_mac_a", 32'(sif.mac_a), 0);
    chk("rst_mac_b", 32'(sif.mac_b), 0);
    chk("rst_result", 32'(sif.result), 0);
    @(negedge clk);

    // Basic run with a stray start mid-run that must be ignored.
    for (int i = 0; i < 5; i++) load(i, i + 1, 9 - i);
    issue_start(5, 95);
    @(negedge clk);
    sif.len = 5'd3; sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    wait_done();

    // Back-to-back: write and start together in the cycle after done.
    @(negedge clk);
    sif.load_en = 1'b1; sif.load_addr = 4'd0; sif.load_a = 8'd2; sif.load_b = 8'd3;
    sa[0] = 8'd2; sb[0] = 8'd3;
    issue_start(1, 6);
    wait_done();
    repeat (2) @(negedge clk);

    // Rejected lengths.
    issue_start(0, 0);
    chk("err0_busy", 32'(sif.busy), 0);
    chk("err0_mac_clr", 32'(sif.mac_clr), 0);
    chk("err0_done", 32'(sif.done), 0);
    chk("err0_result", 32'(sif.result), 6);
    @(negedge clk);
    issue_start(17, 0);
    chk("err17_busy", 32'(sif.busy), 0);
    chk("err17_mac_clr", 32'(sif.mac_clr), 0);
    chk("err17_result", 32'(sif.result), 6);
    @(negedge clk);

    // Writes during STREAM are dropped; shadow is left untouched.
    load(0, 1, 9);
    issue_start(5, 95);
    @(negedge clk);
    sif.load_en = 1'b1; sif.load_addr = 4'd2; sif.load_a = 8'd100; sif.load_b = 8'd100;
    @(negedge clk);
    sif.load_en = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    issue_start(5, 95);
    wait_done();
    repeat (2) @(negedge clk);

    // Full-length worst case.
    for (int i = 0; i < N_MAX; i++) load(i, 255, 255);
    issue_start(16, 22'd1040400);
    wait_done();
    repeat (2) @(negedge clk);

    // Reset during STREAM aborts the run and clears memory.
    issue_start(8, 22'd520200);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    res_q.delete();
    pair_q.delete();
    busy_chk_cyc = -1;
    for (int i = 0; i < N_MAX; i++) begin sa[i] = '0; sb[i] = '0; end
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_busy", 32'(sif.busy), 0);
    chk("mid_rst_mac_a", 32'(sif.mac_a), 0);
    chk("mid_rst_mac_b", 32'(sif.mac_b), 0);
    chk("mid_rst_result", 32'(sif.result), 0);
    chk("mid_rst_done", 32'(sif.done), 0);
    repeat (20) @(negedge clk);
    issue_start(16, 0);
    wait_done();
    repeat (4) @(negedge clk);

    if (res_q.size() != 0 || pair_q.size() != 0 || err_q.size() != 0) flag("queues_not_drained");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mac_dot_sequencer.md
Name: mac_dot_sequencer

Overview:
- Operand sequencer that sits directly upstream of top_mac and also closes the loop on its output.
- Holds two operand vectors of up to N_MAX 8-bit elements, loaded by a host.
- On start it clears the MAC, then streams one (a,b) pair per clock into top_mac, waits out the MAC latency, and captures the 22-bit accumulated y as a dot-product result with a done pulse.

Parameters:
- N_MAX, 16, maximum vector length; element address width is clog2(N_MAX).
- DW, 8, operand width; matches top_mac a/b.
- ACCW, 22, accumulator width; matches top_mac y.
- MAC_LAT, 1, clock cycles from a pair being presented on mac_a/mac_b until it is reflected in mac_y.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- load_en  in  1  write strobe for the operand memory.
- load_addr  in  clog2(N_MAX)  element index to write.
- load_a  in  DW  element value for vector A.
- load_b  in  DW  element value for vector B.
- len  in  clog2(N_MAX)+1  vector length, sampled on start.
- start  in  1  single-cycle request to run a dot product.
- busy  out  1  high from the cycle after an accepted start until the cycle done is asserted, inclusive.
- err  out  1  one-cycle pulse when start is rejected.
- done  out  1  one-cycle pulse; result is valid in the same cycle.
- result  out  ACCW  last captured dot product; holds until the next done or reset.
- mac_clr  out  1  drives top_mac rst (active-high).
- mac_a  out  DW  operand a to top_mac.
- mac_b  out  DW  operand b to top_mac.
- mac_y  in  ACCW  accumulator output of top_mac.

Behaviour:
- All outputs are registered.
- Reset (rst==0 at a rising edge):
  - State goes to IDLE.
  - busy, err, done, mac_clr are 0.
  - mac_a, mac_b, result are 0.
  - Element counter is 0 and all memory entries are 0.
  - Reset takes priority over every other input, including mid-run; the aborted run produces no done.
- Memory write:
  - When load_en=1 in IDLE, A[load_addr]<=load_a and B[load_addr]<=load_b.
  - load_en is ignored when state!=IDLE.
  - load_addr>=N_MAX is ignored.
- States are IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE:
  - mac_a=mac_b=0, so the MAC holds its value.
  - start with 1<=len<=N_MAX: latch len, counter<=0, go to CLEAR.
  - start with len==0 or len>N_MAX: err=1 for one cycle, stay in IDLE.
  - A start that coincides with load_en: the write completes and the run uses the new contents from CLEAR onward.
- CLEAR:
  - Lasts one cycle with mac_clr=1 and mac_a=mac_b=0, then go to STREAM.
- STREAM:
  - Each cycle mac_a=A[counter], mac_b=B[counter], mac_clr=0, and counter increments.
  - When the pair with counter==len-1 has been presented, go to DRAIN.
  - Exactly len pairs are presented on consecutive cycles with no bubbles.
- DRAIN:
  - mac_a=mac_b=0 for MAC_LAT cycles; zero products keep the accumulator steady.
  - Then go to DONE.
- DONE:
  - result<=mac_y and done=1 for one cycle, then go to IDLE.
- busy is high in CLEAR, STREAM, DRAIN and DONE.
- start while busy is ignored, with no err.
- Timing: with start accepted at edge k, the first pair appears at edge k+2 and done is high in the cycle after edge k+2+len+MAC_LAT. Total run is len+MAC_LAT+3 cycles from start to the end of the done pulse.
- Arithmetic:
  - Unsigned operands; the accumulation itself is performed by top_mac.
  - The sequencer does no saturation.
  - N_MAX*(2^DW-1)^2 must fit in ACCW; the defaults give 1,040,400 < 2^22.
- Back-to-back runs: start may be asserted the cycle after done. Every run begins with CLEAR, so no residue carries over from a prior run.

Test Plan:
- Load A={1,2,3,4,5}, B={9,8,7,6,5}, len=5, start; DUT connected to top_mac -> five consecutive pairs (1,9)..(5,5) on mac_a/mac_b, then result=95 with a one-cycle done exactly len+MAC_LAT+3 cycles after start; busy deasserts the cycle after done.
- Load all 16 entries with 255/255, len=16 -> result=1,040,400 (0x0FE010), with no wrap.
- start with len=0, then with len=17 -> err pulses one cycle each time; busy, mac_clr and done stay 0; result unchanged.
- Run 1 with A={1,2,3,4,5}, B={9,8,7,6,5}, len=5 gives 95. Immediately after done, load A[0]=2, B[0]=3 and start with len=1 -> result=6, proving the MAC clear; start pulsed mid-run 1 has no effect.
- Drive rst=0 for one cycle during STREAM of a len=8 run -> next cycle: IDLE, busy=0, mac_a=mac_b=0, result=0, memory=0, and no done ever follows.
- Assert load_en with addr=2 during STREAM -> memory unchanged; a rerun of the same vectors gives the same result.
